// File: rtl/legv8_data_mem_ctrl_if.sv
// rtl/legv8_data_mem_ctrl_if.sv - CPU-to-data-memory request/handshake interface
// The 64-bit bidirectional data bus stays a plain inout port on the controller
// so the tristate driver lives at the module boundary.
interface legv8_data_mem_ctrl_if;
   logic [31:0] address;
   logic        mem_read;
   logic        mem_write;
   logic        ready;
   logic        error;
   logic        busy;

   modport master (
      output address, mem_read, mem_write,
      input  ready, error, busy
   );

   modport slave (
      input  address, mem_read, mem_write,
      output ready, error, busy
   );
endinterface

// File: rtl/legv8_data_mem_ctrl.sv
// rtl/legv8_data_mem_ctrl.sv - LEGv8 data-memory slave with wait states (optional MEM_CTRL_ALIGN_CHECK_EN)
module legv8_data_mem_ctrl #(
   parameter int          ADDR_WIDTH  = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   legv8_data_mem_ctrl_if.slave  bus,
   inout  wire [63:0]            data
);

   localparam int         DEPTH   = 1 << ADDR_WIDTH;
   localparam int         TAG_LSB = ADDR_WIDTH + 3;
   localparam logic [3:0] WS      = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic                  error_q, error_d;
   logic                  op_rd_q, op_rd_d;
   logic                  op_wr_q, op_wr_d;
   logic                  fault_q, fault_d;
   logic                  hold_q, hold_d;
   logic                  ignore_q, ignore_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [63:0]           wdata_q, wdata_d;
   logic [63:0]           rdata_q, rdata_d;

   logic [63:0]           mem [DEPTH];

   logic                  hit;
   logic                  req;
   logic                  fault_in;
   logic [63:0]           rd_value;
   logic [63:0]           data_out;
   logic                  drive_en;

   assign hit = (bus.address[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
   assign req = bus.mem_read | bus.mem_write;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
   assign fault_in = (bus.mem_read & bus.mem_write) | (bus.address[2:0] != 3'd0);
`else
   // Byte offset is truncated to the doubleword.
   wire unused_offset = ^bus.address[2:0];
   assign fault_in = bus.mem_read & bus.mem_write;
`endif

   // Faulted transfers never look at the array; their read data is zero.
   assign rd_value = fault_q ? 64'd0 : mem[idx_q];

   // Drive during ACCESS straight from the array, then from the captured copy
   // for as long as the CPU keeps mem_read high.
   assign data_out = (state_q == S_ACCESS) ? rd_value : rdata_q;
   assign drive_en = bus.mem_read & op_rd_q & ~op_wr_q &
                     ((state_q == S_ACCESS) | hold_q);
   assign data     = drive_en ? data_out : {64{1'bz}};

   assign bus.ready = ready_q;
   assign bus.error = error_q;
   assign bus.busy  = busy_q;

   // Next-state and registered-output computation for the transfer FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      ready_d  = 1'b0;
      error_d  = 1'b0;
      op_rd_d  = op_rd_q;
      op_wr_d  = op_wr_q;
      fault_d  = fault_q;
      hold_d   = hold_q & bus.mem_read;
      ignore_d = ignore_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      case (state_q)
         S_IDLE: begin
            ignore_d = 1'b0;
            if (!ignore_q && hit && req) begin
               op_rd_d = bus.mem_read;
               op_wr_d = bus.mem_write;
               fault_d = fault_in;
               idx_d   = bus.address[TAG_LSB-1:3];
               hold_d  = 1'b0;
               if (bus.mem_write) begin
                  wdata_d = data;
               end
               busy_d = 1'b1;
               cnt_d  = WS;
               if (WS == 4'd0) begin
                  state_d = S_ACCESS;
                  ready_d = 1'b1;
                  error_d = fault_in;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_ACCESS;
               ready_d = 1'b1;
               error_d = fault_q;
            end
         end
         S_ACCESS: begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            ignore_d = 1'b1;
            rdata_d  = rd_value;
            hold_d   = op_rd_q & ~op_wr_q & bus.mem_read;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Control and datapath registers; reset aborts any transfer in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         error_q  <= 1'b0;
         op_rd_q  <= 1'b0;
         op_wr_q  <= 1'b0;
         fault_q  <= 1'b0;
         hold_q   <= 1'b0;
         ignore_q <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= 64'd0;
         rdata_q  <= 64'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         error_q  <= error_d;
         op_rd_q  <= op_rd_d;
         op_wr_q  <= op_wr_d;
         fault_q  <= fault_d;
         hold_q   <= hold_d;
         ignore_q <= ignore_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   // Array write port; contents survive reset, and commit happens only at the end of ACCESS.
   always_ff @(posedge clock) begin
      if (state_q == S_ACCESS && op_wr_q && !fault_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_legv8_data_mem_ctrl.sv
// tb/tb_legv8_data_mem_ctrl.sv - scoreboard testbench for legv8_data_mem_ctrl
module tb_legv8_data_mem_ctrl;

   localparam int          WS       = 1;
   localparam logic [63:0] RELEASED = {64{1'b1}};
   localparam logic [63:0] V10      = 64'hDEAD_BEEF_0123_4567;
   localparam logic [63:0] V18      = 64'hCAFE_F00D_1234_5678;
   localparam logic [63:0] V08      = 64'h5555_AAAA_0F0F_F0F0;
   localparam logic [63:0] VTOP     = 64'h0123_4567_89AB_CDEF;

   logic        clock;
   logic        reset;
   logic        tb_drv;
   logic [63:0] tb_wdata;
   wire  [63:0] data_bus;
   int          cyc;
   int          n_cmp;
   int          n_fail;

   legv8_data_mem_ctrl_if bus ();

   assign data_bus = tb_drv ? tb_wdata : {64{1'bz}};

   genvar g;
   for (g = 0; g < 64; g++) begin : g_pu
      pullup (data_bus[g]);
   end

   legv8_data_mem_ctrl #(
      .ADDR_WIDTH  (8),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (WS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .data  (data_bus)
   );

   typedef struct {
      string       name;
      int          accept_cyc;
      logic        err;
      logic        chk_data;
      logic [63:0] rdata;
   } exp_t;

   exp_t sb_q[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every ready pulse is matched against the oldest expected transfer.
   always @(negedge clock) begin
      if (bus.ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ready", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, "_latency"}, 64'(cyc - e.accept_cyc + 1), 64'(WS + 1));
            chk({e.name, "_error"}, {63'd0, bus.error}, {63'd0, e.err});
            if (e.chk_data) chk({e.name, "_rdata"}, data_bus, e.rdata);
         end
      end else if (bus.error) begin
         chk("error_without_ready", 64'd1, 64'd0);
      end
   end

   task automatic xfer(input string name, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [63:0] wd, input logic exp_err, input logic [63:0] exp_rd);
      exp_t e;
      bit   seen;
      @(negedge clock);
      bus.address   = addr;
      bus.mem_read  = rd;
      bus.mem_write = wr;
      tb_wdata      = wd;
      tb_drv        = wr & ~rd;
      @(posedge clock);
      #1;
      e.name       = name;
      e.accept_cyc = cyc;
      e.err        = exp_err;
      e.chk_data   = rd & ~wr;
      e.rdata      = exp_rd;
      sb_q.push_back(e);
      chk({name, "_busy"}, {63'd0, bus.busy}, 64'd1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         if (bus.ready) seen = 1;
      end
      if (!seen) chk({name, "_ready_timeout"}, 64'd0, 64'd1);
      @(negedge clock);
      if (rd && !wr) chk({name, "_hold"}, data_bus, exp_rd);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      tb_drv        = 1'b0;
      @(negedge clock);
      chk({name, "_released"}, data_bus, RELEASED);
      chk({name, "_idle"}, {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      n_cmp         = 0;
      n_fail        = 0;
      cyc           = 0;
      reset         = 1'b0;
      tb_drv        = 1'b0;
      tb_wdata      = 64'd0;
      bus.address   = 32'd0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_ready", {63'd0, bus.ready}, 64'd0);
      chk("rst_error", {63'd0, bus.error}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_data", data_bus, RELEASED);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      xfer("wr10", 1'b0, 1'b1, 32'h10, V10, 1'b0, 64'd0);
      xfer("rd10", 1'b1, 1'b0, 32'h10, 64'd0, 1'b0, V10);
      xfer("wr18", 1'b0, 1'b1, 32'h18, V18, 1'b0, 64'd0);
      xfer("wr08", 1'b0, 1'b1, 32'h08, V08, 1'b0, 64'd0);
      xfer("wr7f8", 1'b0, 1'b1, 32'h7F8, VTOP, 1'b0, 64'd0);
      xfer("rd7f8", 1'b1, 1'b0, 32'h7F8, 64'd0, 1'b0, VTOP);

      xfer("both08", 1'b1, 1'b1, 32'h08, 64'hFFFF_0000_FFFF_0000, 1'b1, 64'd0);
      xfer("rd08", 1'b1, 1'b0, 32'h08, 64'd0, 1'b0, V08);

      // Write of 1 to 0x18 aborted by reset while in WAIT.
      @(negedge clock);
      bus.address   = 32'h18;
      bus.mem_write = 1'b1;
      tb_wdata      = 64'd1;
      tb_drv        = 1'b1;
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_wait_busy", {63'd0, bus.busy}, 64'd0);
      @(negedge clock);
      bus.mem_write = 1'b0;
      tb_drv        = 1'b0;
      reset         = 1'b1;
      @(negedge clock);
      xfer("rd18", 1'b1, 1'b0, 32'h18, 64'd0, 1'b0, V18);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
      xfer("rd13", 1'b1, 1'b0, 32'h13, 64'd0, 1'b1, 64'd0);
`else
      xfer("rd13", 1'b1, 1'b0, 32'h13, 64'd0, 1'b0, V10);
`endif

      // Miss: another slave owns this address.
      @(negedge clock);
      bus.address  = 32'h1000_0000;
      bus.mem_read = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("miss_busy", {63'd0, bus.busy}, 64'd0);
         chk("miss_data", data_bus, RELEASED);
      end
      bus.mem_read = 1'b0;
      @(negedge clock);

      // Reset asserted during ACCESS of a read that is driving the bus.
      @(negedge clock);
      bus.address  = 32'h10;
      bus.mem_read = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("mid_ready_pre", {63'd0, bus.ready}, 64'd1);
      chk("mid_data_pre", data_bus, V10);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_ready", {63'd0, bus.ready}, 64'd0);
      chk("mid_error", {63'd0, bus.error}, 64'd0);
      chk("mid_busy", {63'd0, bus.busy}, 64'd0);
      chk("mid_data", data_bus, RELEASED);
      @(negedge clock);
      bus.mem_read = 1'b0;
      reset        = 1'b1;
      @(negedge clock);

      xfer("rd10_post", 1'b1, 1'b0, 32'h10, 64'd0, 1'b0, V10);

      repeat (4) @(negedge clock);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
